vga_scan_controller: RTL

//  Generates VGA raster timing: pixel address scan (xAddr/yAddr/inDisplay) consumed by the
//  box/ball/paddle pixel renderers, plus hsync/vsync for the DAC/connector. Sits between the

---
 rtl/vga_scan_controller.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vga_scan_controller.sv
// VGA raster timing generator: pixel-rate scan counters, display-enable decode,
// delayed sync outputs and a one-clock pulse on entry to vertical blank.
module vga_scan_controller #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clock,
  input  logic       reset,
  output logic [9:0] xAddr,
  output logic [9:0] yAddr,
  output logic       inDisplay,
  output logic       hsync,
  output logic       vsync,
  output logic       frameDone
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_PRE_VBL  = 10'(V_ACTIVE - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gBadTotal
    $error("vga_scan_controller: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || SYNC_DELAY < 0) begin : gBadParam
    $error("vga_scan_controller: CLK_DIV must be >=1 and SYNC_DELAY >=0");
  end

  logic [DIV_W-1:0] divCnt;
  logic             tick;
  logic [10:0]      xWide;
  logic [10:0]      yWide;
  logic             hRaw;
  logic             vRaw;

  assign tick = (divCnt == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divCnt <= '0;
    end else begin
      divCnt <= tick ? '0 : divCnt + DIV_W'(1);
    end
  end

  // x wraps into the next line on the same tick that y advances
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xAddr <= '0;
      yAddr <= '0;
    end else if (tick) begin
      if (xAddr == X_LAST) begin
        xAddr <= '0;
        yAddr <= (yAddr == Y_LAST) ? '0 : yAddr + 10'd1;
      end else begin
        xAddr <= xAddr + 10'd1;
      end
    end
  end

  // the frame pulse lines up with the first clock the counters show (0, V_ACTIVE)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frameDone <= 1'b0;
    end else begin
      frameDone <= tick && (xAddr == X_LAST) && (yAddr == Y_PRE_VBL);
    end
  end

  assign xWide = {1'b0, xAddr};
  assign yWide = {1'b0, yAddr};

  assign inDisplay = !reset && (xWide < H_ACT_END) && (yWide < V_ACT_END);

  assign hRaw = ((xWide >= HS_START) && (xWide < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vRaw = ((yWide >= VS_START) && (yWide < VS_END)) ? SYNC_POL : ~SYNC_POL;

  if (SYNC_DELAY == 0) begin : gSyncComb
    assign hsync = hRaw;
    assign vsync = vRaw;
  end else begin : gSyncPipe
    logic [SYNC_DELAY-1:0] hPipe;
    logic [SYNC_DELAY-1:0] vPipe;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        hPipe <= {SYNC_DELAY{~SYNC_POL}};
        vPipe <= {SYNC_DELAY{~SYNC_POL}};
      end else begin
        hPipe[0] <= hRaw;
        vPipe[0] <= vRaw;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          hPipe[i] <= hPipe[i-1];
          vPipe[i] <= vPipe[i-1];
        end
      end
    end

    assign hsync = hPipe[SYNC_DELAY-1];
    assign vsync = vPipe[SYNC_DELAY-1];
  end

endmodule
